mult_seq_unit: RTL and testbench
================================

Name: mult_seq_unit

Overview:
- Parametrised signed (two's-complement) sequential shift-add multiplier: datapath plus its own control FSM.
- Holds sign-extension bit X, accumulator A (WIDTH), multiplier B (WIDTH), and multiplicand M latched at start.
- Sits between the switch/button input logic and the hex display drivers of the multiplier top level.
- Produces a 2*WIDTH-bit product, with a Start/Done handshake and support for chained multiplication.

Parameters:
- WIDTH, 8, operand width in bits (>=2); product is 2*WIDTH bits; step counter is $clog2(WIDTH) bits.

Ports:
- Clk  in  1  system clock, rising-edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  level; begins a multiply when sampled high in IDLE.
- Clear_Load  in  1  in IDLE: clear X and A, load B from Din.
- Din  in  WIDTH  operand input; B source on Clear_Load, M source on Start.
- Busy  out  1  high in ADD/SHIFT states.
- Done  out  1  high in DONE state.
- X  out  1  sign-extension bit.
- Aout  out  WIDTH  accumulator (product high half).
- Bout  out  WIDTH  multiplier register (product low half).
- Product  out  2*WIDTH  equals {Aout,Bout}.

Behaviour:
- Reset (Reset_n low, asynchronous):
  - State goes to IDLE.
  - X, A, B, M and the step counter are all zero.
  - Busy=0, Done=0, Product=0.
- States: IDLE, ADD, SHIFT, DONE; the enum lives in the package.
- IDLE, priority Start > Clear_Load:
  - Start=1: M<=Din, A<=0, X<=0, cnt<=0, go to ADD. B is kept, which enables chaining.
  - Else Clear_Load=1: A<=0, X<=0, B<=Din. Stay in IDLE.
  - Else: hold all registers.
- ADD:
  - If B[0]=0: no change.
  - If B[0]=1 and cnt<WIDTH-1: {X,A} <= {A[W-1],A} + {M[W-1],M}, computed in (WIDTH+1)-bit arithmetic with the carry-out discarded.
  - If B[0]=1 and cnt==WIDTH-1: {X,A} <= {A[W-1],A} - {M[W-1],M}. This is the sign-bit correction.
  - Always go to SHIFT next.
- SHIFT:
  - Arithmetic right shift: {X,A,B} <= {X, X, A, B[W-1:1]}. X is unchanged.
  - cnt==WIDTH-1: go to DONE. Otherwise cnt<=cnt+1 and return to ADD.
- DONE:
  - Registers hold. Done=1.
  - Return to IDLE only when Start=0, so a held Start never retriggers.
- Latency: Start sampled on edge t0; Done is first high after edge t0+2*WIDTH. The result is valid from that point until the next Start or Clear_Load.
- Inputs while Busy:
  - Clear_Load and Din are ignored; M is already latched.
  - Start is ignored.
- Result: Product is the exact signed product M*B_initial for all operand values.
  - X equals the product sign, except for results of zero.
- Boundary case: M = B = -2^(W-1) gives +2^(2W-2) with no overflow (W=8: 0x4000).
- Chaining: Start from IDLE after DONE multiplies the new Din by the previous Product[W-1:0]. B is retained and A is cleared.
- Reset asserted mid-operation aborts immediately to the reset values. The FSM returns to IDLE once Reset_n is released, even if Start is high (no partial state kept).

Decomposition:
- Package mult_seq_pkg holds:
  - typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} mult_state_t.
  - A localparam function for the counter width.
- Sub-module shift_reg_n (WIDTH param): synchronous load, shift-right with Shift_In, Shift_Out. Async active-low reset. Instantiated for A and B.
- X, M, the counter and the FSM live in mult_seq_unit.

Test Plan (WIDTH=8):
- Clear_Load with Din=0x05; Start with Din=0x07 -> Done 16 cycles after the Start edge; Product=0x0023, X=0; Busy high for exactly 16 cycles.
- B=0x05, M=0xF9 (-7) -> Product=0xFFDD, X=1. Then B=0xFB (-5), M=0x07 -> 0xFFDD, X=1. Then B=0xFB, M=0xF9 -> 0x0023, X=0.
- B=0x80, M=0x80 -> Product=0x4000, X=0. Then B=0x7F, M=0x80 -> 0xC080, X=1. Then B=0x00, M=0xFF -> 0x0000.
- Start held high through DONE -> no second run, Done stays 1. Drop Start, then Start again with Din=0x02 -> Product=0x0046 (chained 0x23*2).
- Mid-run (cycle 7), pulse Clear_Load with Din=0xAA and toggle Din -> ignored; result is unchanged from the reference product.
- Assert Reset_n=0 asynchronously between edges during SHIFT -> Busy/Done/Product go to 0 immediately. After release with Start=0 -> IDLE; a new run is correct.

Source files
------------

// File: rtl/mult_seq_pkg.sv
// Shared types and helpers for the sequential signed multiplier.
package mult_seq_pkg;

  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} mult_state_t;

  // Width of the step counter for a given operand width (never below 1 bit).
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/mult_seq_unit_shift_reg_n.sv
// Loadable right-shift register used for the accumulator and multiplier.
module shift_reg_n #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Load,
  input  logic             Shift_En,
  input  logic             Shift_In,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             Shift_Out
);

  // Load has priority over shift; otherwise hold.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      Q <= '0;
    else if (Load)
      Q <= D;
    else if (Shift_En)
      Q <= {Shift_In, Q[WIDTH-1:1]};
  end

  assign Shift_Out = Q[0];

endmodule

// File: rtl/mult_seq_unit.sv
// Signed shift-add multiplier: X/A/B/M datapath with its control FSM.
module mult_seq_unit
  import mult_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Start,
  input  logic               Clear_Load,
  input  logic [WIDTH-1:0]   Din,
  output logic               Busy,
  output logic               Done,
  output logic               X,
  output logic [WIDTH-1:0]   Aout,
  output logic [WIDTH-1:0]   Bout,
  output logic [2*WIDTH-1:0] Product
);

  localparam int unsigned     CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  mult_state_t       state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  m_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic              x_q;
  logic              a_lsb, b_lsb;
  logic              load_start, load_clr, add_en, shift_en;
  logic              a_load;
  logic [WIDTH-1:0]  a_d;
  logic [WIDTH:0]    ext_a, ext_m, sum;

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic; DONE waits for Start low so a held Start cannot retrigger.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (Start) state_nxt = ADD;
      ADD:   state_nxt = SHIFT;
      SHIFT: state_nxt = (cnt == LAST) ? DONE : ADD;
      DONE:  if (!Start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output and datapath-control decode.
  always_comb begin
    Busy       = (state == ADD) || (state == SHIFT);
    Done       = (state == DONE);
    load_start = (state == IDLE) && Start;
    load_clr   = (state == IDLE) && !Start && Clear_Load;
    add_en     = (state == ADD) && b_lsb;
    shift_en   = (state == SHIFT);
  end

  // Sign-extended add, or subtract on the final step to weight the multiplier sign bit negatively.
  always_comb begin
    ext_a = {a_q[WIDTH-1], a_q};
    ext_m = {m_q[WIDTH-1], m_q};
    sum   = (cnt == LAST) ? (ext_a - ext_m) : (ext_a + ext_m);
    a_load = load_start || load_clr || add_en;
    a_d    = add_en ? sum[WIDTH-1:0] : '0;
  end

  // Sign-extension bit, multiplicand and step counter.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      x_q <= 1'b0;
      m_q <= '0;
      cnt <= '0;
    end else begin
      if (load_start || load_clr)
        x_q <= 1'b0;
      else if (add_en)
        x_q <= sum[WIDTH];
      if (load_start) begin
        m_q <= Din;
        cnt <= '0;
      end else if (shift_en && cnt != LAST) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  shift_reg_n #(.WIDTH(WIDTH)) u_a_reg (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Load      (a_load),
    .Shift_En  (shift_en),
    .Shift_In  (x_q),
    .D         (a_d),
    .Q         (a_q),
    .Shift_Out (a_lsb)
  );

  shift_reg_n #(.WIDTH(WIDTH)) u_b_reg (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Load      (load_clr),
    .Shift_En  (shift_en),
    .Shift_In  (a_lsb),
    .D         (Din),
    .Q         (b_q),
    .Shift_Out (b_lsb)
  );

  assign X       = x_q;
  assign Aout    = a_q;
  assign Bout    = b_q;
  assign Product = {a_q, b_q};

endmodule

// File: tb/tb_mult_seq_unit.sv
// Directed bench for mult_seq_unit at WIDTH=8.
module tb_mult_seq_unit;

  logic        Clk;
  logic        Reset_n;
  logic        Start;
  logic        Clear_Load;
  logic [7:0]  Din;
  logic        Busy;
  logic        Done;
  logic        X;
  logic [7:0]  Aout;
  logic [7:0]  Bout;
  logic [15:0] Product;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  b;
    logic [7:0]  m;
    logic [15:0] prod;
    logic        x;
    bit          chk_x;
  } vec_t;

  vec_t vecs[9];

  mult_seq_unit #(.WIDTH(8)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Start      (Start),
    .Clear_Load (Clear_Load),
    .Din        (Din),
    .Busy       (Busy),
    .Done       (Done),
    .X          (X),
    .Aout       (Aout),
    .Bout       (Bout),
    .Product    (Product)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Ends on a negedge with IDLE guaranteed and B loaded.
  task automatic do_load(input logic [7:0] b);
    Start = 1'b0;
    repeat (2) @(negedge Clk);
    Clear_Load = 1'b1;
    Din = b;
    @(negedge Clk);
    Clear_Load = 1'b0;
  endtask

  // Called just after a negedge in IDLE; returns #1 after the edge where Done rises.
  task automatic do_start(input logic [7:0] m, input bit hold, input bit disturb,
                          output int cyc, output int busy_cnt);
    Start = 1'b1;
    Din = m;
    @(posedge Clk);
    #1;
    busy_cnt = Busy ? 1 : 0;
    if (!hold) Start = 1'b0;
    Din = 8'h3C;
    cyc = 0;
    while (!Done && cyc < 40) begin
      @(posedge Clk);
      #1;
      cyc++;
      if (Busy) busy_cnt++;
      if (disturb) begin
        case (cyc)
          7:  begin Clear_Load = 1'b1; Din = 8'hAA; end
          8:  begin Clear_Load = 1'b0; Din = 8'h55; end
          9:  Start = 1'b1;
          10: Start = 1'b0;
          default: ;
        endcase
      end
    end
  endtask

  task automatic check_result(input string name, input vec_t v, input int cyc, input int bc);
    check({name, " latency"}, cyc, 16);
    check({name, " busy_cycles"}, bc, 16);
    check({name, " product"}, {16'h0, Product}, {16'h0, v.prod});
    check({name, " concat"}, {16'h0, Aout, Bout}, {16'h0, v.prod});
    if (v.chk_x) check({name, " x"}, {31'h0, X}, {31'h0, v.x});
  endtask

  initial begin
    int   cyc, bc;
    vec_t v;

    vecs[0] = '{8'h05, 8'h07, 16'h0023, 1'b0, 1'b1};
    vecs[1] = '{8'h05, 8'hF9, 16'hFFDD, 1'b1, 1'b1};
    vecs[2] = '{8'hFB, 8'h07, 16'hFFDD, 1'b1, 1'b1};
    vecs[3] = '{8'hFB, 8'hF9, 16'h0023, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 8'h80, 16'h4000, 1'b0, 1'b1};
    vecs[5] = '{8'h7F, 8'h80, 16'hC080, 1'b1, 1'b1};
    vecs[6] = '{8'h00, 8'hFF, 16'h0000, 1'b0, 1'b0};
    vecs[7] = '{8'h7F, 8'h7F, 16'h3F01, 1'b0, 1'b1};
    vecs[8] = '{8'hFF, 8'hFF, 16'h0001, 1'b0, 1'b1};

    Reset_n = 1'b0;
    Start = 1'b0;
    Clear_Load = 1'b0;
    Din = 8'h00;
    repeat (2) @(negedge Clk);
    check("reset busy", {31'h0, Busy}, 32'h0);
    check("reset done", {31'h0, Done}, 32'h0);
    check("reset product", {16'h0, Product}, 32'h0);
    check("reset x", {31'h0, X}, 32'h0);
    Reset_n = 1'b1;

    foreach (vecs[i]) begin
      do_load(vecs[i].b);
      do_start(vecs[i].m, 1'b0, 1'b0, cyc, bc);
      check_result($sformatf("vec%0d", i), vecs[i], cyc, bc);
    end

    // Start held through DONE must not retrigger; then chain with Din=2.
    do_load(8'h05);
    do_start(8'h07, 1'b1, 1'b0, cyc, bc);
    v = '{8'h05, 8'h07, 16'h0023, 1'b0, 1'b1};
    check_result("held", v, cyc, bc);
    repeat (5) begin
      @(posedge Clk);
      #1;
      check("held done", {31'h0, Done}, 32'h1);
      check("held busy", {31'h0, Busy}, 32'h0);
    end
    check("held product", {16'h0, Product}, 32'h0023);
    Start = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    do_start(8'h02, 1'b0, 1'b0, cyc, bc);
    v = '{8'h23, 8'h02, 16'h0046, 1'b0, 1'b1};
    check_result("chain", v, cyc, bc);

    // Clear_Load, Din and Start activity mid-run is ignored.
    do_load(8'h05);
    do_start(8'hF9, 1'b0, 1'b1, cyc, bc);
    v = '{8'h05, 8'hF9, 16'hFFDD, 1'b1, 1'b1};
    check_result("disturb", v, cyc, bc);

    // Asynchronous reset during SHIFT.
    do_load(8'h05);
    Start = 1'b1;
    Din = 8'h07;
    @(posedge Clk);
    #1 Start = 1'b0;
    @(posedge Clk);
    #1;
    check("pre-reset busy", {31'h0, Busy}, 32'h1);
    #2 Reset_n = 1'b0;
    #1;
    check("async busy", {31'h0, Busy}, 32'h0);
    check("async done", {31'h0, Done}, 32'h0);
    check("async product", {16'h0, Product}, 32'h0);
    check("async x", {31'h0, X}, 32'h0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    check("post-reset idle busy", {31'h0, Busy}, 32'h0);
    check("post-reset idle done", {31'h0, Done}, 32'h0);
    do_load(8'h05);
    do_start(8'h07, 1'b0, 1'b0, cyc, bc);
    v = '{8'h05, 8'h07, 16'h0023, 1'b0, 1'b1};
    check_result("after-reset", v, cyc, bc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
